// File: rtl/neuron_cfg_pkg.sv
// Shared opcodes, decoder states and control-byte field layout for neuron_cfg_ctrl.
// Checksummed packets are enabled by defining NEURON_CFG_CHECKSUM_EN.
package neuron_cfg_pkg;

    localparam logic [7:0] OP_SET_CTRL        = 8'h01;
    localparam logic [7:0] OP_ADDR_WEIGHT_SET = 8'h02;
    localparam logic [7:0] OP_WEIGHT_SET      = 8'h03;
    localparam logic [7:0] OP_END             = 8'hFF;
    localparam logic [7:0] ID_BROADCAST       = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_CTRL,
        S_ADDR,
        S_VALUE,
        S_CHK,
        S_ISSUE
    } state_t;

    // Layout of the first control byte (c0); init_mode_acc lives in bit 0 of c1.
    localparam int DECAY_LSB       = 0;
    localparam int DECAY_W         = 3;
    localparam int ADDER_INIT_LSB  = 3;
    localparam int ADDER_INIT_W    = 3;
    localparam int ADDER_MODEL_LSB = 6;
    localparam int ADDER_MODEL_W   = 2;
    localparam int ACC_INIT_BIT    = 0;

endpackage

// File: rtl/neuron_cfg_shift.sv
// LSB-first byte assembler: shifts whole bytes in and flags the last byte of a W-bit field.
module neuron_cfg_shift #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] data,
    output logic         last
);

    localparam int N_BYTES = (W + 7) / 8;
    localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [N_BYTES*8-1:0] sr;
    logic [CNT_W-1:0]     cnt;

    assign last = (cnt == CNT_W'(N_BYTES - 1));
    assign data = sr[W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // New bytes enter at the top so the first byte received ends up least significant.
    generate
        if (N_BYTES == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else if (shift) sr <= byte_in;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else if (shift) sr <= {byte_in, sr[N_BYTES*8-1:8]};
            end
        end
    endgenerate

endmodule

// File: rtl/neuron_cfg_ctrl.sv
// Byte-serial configuration packet decoder driving control and weight write strobes.
// Optional trailing XOR checksum per packet: define NEURON_CFG_CHECKSUM_EN.
module neuron_cfg_ctrl
    import neuron_cfg_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int ADDR_W    = 10,
    parameter int VALUE_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic [N_NEURONS-1:0] cfg_sel,
    output logic                 ctrl_we,
    output logic [2:0]           decay_mode,
    output logic [2:0]           init_mode_adder,
    output logic [1:0]           adder_model,
    output logic                 init_mode_acc,
    output logic                 wt_we,
    output logic [ADDR_W-1:0]    wt_addr,
    output logic [VALUE_W-1:0]   wt_value,
    output logic                 neuron_mode,
    output logic                 run_start,
    output logic                 err
);

    // Handshake: a byte moves on any cycle with in_valid && in_ready; in_ready drops only in ISSUE.
`ifdef NEURON_CFG_CHECKSUM_EN
    localparam state_t DATA_DONE = S_CHK;
`else
    localparam state_t DATA_DONE = S_ISSUE;
`endif

    state_t state, state_nxt;
    logic [7:0] op_q, id_q, c0_q;
    logic       acc_q, ctrl_idx, neuron_mode_q, run_start_q, err_q;
    logic [2:0] decay_q, adder_init_q;
    logic [1:0] adder_model_q;
    logic       acc_init_q;
    logic [ADDR_W-1:0]  wt_addr_q;
    logic [VALUE_W-1:0] wt_value_q;
    logic [ADDR_W-1:0]  addr_data;
    logic [VALUE_W-1:0] val_data;
    logic accept, is_cmd, addr_last, val_last, id_ok, chk_ok, issue_ok;

    assign in_ready = (state != S_ISSUE);
    assign accept   = in_valid && in_ready;
    assign is_cmd   = (in_data == OP_SET_CTRL) || (in_data == OP_ADDR_WEIGHT_SET)
                   || (in_data == OP_WEIGHT_SET);
    assign id_ok    = (id_q == ID_BROADCAST) || ({24'd0, id_q} < 32'(N_NEURONS));

`ifdef NEURON_CFG_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       chk_ok_q;
    assign chk_ok = chk_ok_q;
`else
    assign chk_ok = 1'b1;
`endif

    assign issue_ok = (state == S_ISSUE) && id_ok && chk_ok;

    neuron_cfg_shift #(.W(ADDR_W)) u_addr_shift (
        .clk(clk), .rst(rst), .clear(accept && state == S_IDLE),
        .shift(accept && state == S_ADDR), .byte_in(in_data),
        .data(addr_data), .last(addr_last)
    );

    neuron_cfg_shift #(.W(VALUE_W)) u_value_shift (
        .clk(clk), .rst(rst), .clear(accept && state == S_IDLE),
        .shift(accept && state == S_VALUE), .byte_in(in_data),
        .data(val_data), .last(val_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_cmd) state_nxt = S_ID;
            S_ID:    if (accept) begin
                         if (op_q == OP_SET_CTRL)             state_nxt = S_CTRL;
                         else if (op_q == OP_ADDR_WEIGHT_SET) state_nxt = S_ADDR;
                         else                                 state_nxt = S_VALUE;
                     end
            S_CTRL:  if (accept && ctrl_idx)  state_nxt = DATA_DONE;
            S_ADDR:  if (accept && addr_last) state_nxt = S_VALUE;
            S_VALUE: if (accept && val_last)  state_nxt = DATA_DONE;
            S_CHK:   if (accept)              state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Field outputs show the new packet's values during its ISSUE cycle and hold afterwards.
    always_comb begin
        decay_mode      = decay_q;
        init_mode_adder = adder_init_q;
        adder_model     = adder_model_q;
        init_mode_acc   = acc_init_q;
        wt_addr         = wt_addr_q;
        wt_value        = wt_value_q;
        if (issue_ok) begin
            if (op_q == OP_SET_CTRL) begin
                decay_mode      = c0_q[DECAY_LSB +: DECAY_W];
                init_mode_adder = c0_q[ADDER_INIT_LSB +: ADDER_INIT_W];
                adder_model     = c0_q[ADDER_MODEL_LSB +: ADDER_MODEL_W];
                init_mode_acc   = acc_q;
            end else if (op_q == OP_ADDR_WEIGHT_SET) begin
                wt_addr  = addr_data;
                wt_value = val_data;
            end else begin
                wt_addr  = wt_addr_q + 1'b1;
                wt_value = val_data;
            end
        end
    end

    always_comb begin
        cfg_sel = '0;
        if (issue_ok) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cfg_sel[i] = (id_q == ID_BROADCAST) || (id_q == 8'(i));
            end
        end
    end

    assign ctrl_we     = issue_ok && (op_q == OP_SET_CTRL);
    assign wt_we       = issue_ok && (op_q != OP_SET_CTRL);
    assign neuron_mode = neuron_mode_q;
    assign run_start   = run_start_q;
    assign err         = err_q || ((state == S_ISSUE) && !(id_ok && chk_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            id_q          <= '0;
            c0_q          <= '0;
            acc_q         <= 1'b0;
            ctrl_idx      <= 1'b0;
            neuron_mode_q <= 1'b1;
            run_start_q   <= 1'b0;
            err_q         <= 1'b0;
            decay_q       <= '0;
            adder_init_q  <= '0;
            adder_model_q <= '0;
            acc_init_q    <= 1'b0;
            wt_addr_q     <= '0;
            wt_value_q    <= '0;
        end else begin
            run_start_q   <= 1'b0;
            err_q         <= 1'b0;
            decay_q       <= decay_mode;
            adder_init_q  <= init_mode_adder;
            adder_model_q <= adder_model;
            acc_init_q    <= init_mode_acc;
            wt_addr_q     <= wt_addr;
            wt_value_q    <= wt_value;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (is_cmd) begin
                            op_q          <= in_data;
                            neuron_mode_q <= 1'b1;
                        end else if (in_data == OP_END) begin
                            neuron_mode_q <= 1'b0;
                            run_start_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    S_ID:   id_q <= in_data;
                    S_CTRL: begin
                        if (!ctrl_idx) c0_q  <= in_data;
                        else           acc_q <= in_data[ACC_INIT_BIT];
                        ctrl_idx <= ~ctrl_idx;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef NEURON_CFG_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q    <= '0;
            chk_ok_q <= 1'b0;
        end else if (accept) begin
            if (state == S_IDLE)     chk_q    <= in_data;
            else if (state == S_CHK) chk_ok_q <= (in_data == chk_q);
            else                     chk_q    <= chk_q ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_cfg_ctrl.sv
// Bench for neuron_cfg_ctrl: directed packets plus random traffic against a packet-level model.
module tb_neuron_cfg_ctrl;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int VW = 32;
    localparam int EW = 60;

    logic          clk, rst, in_valid, in_ready;
    logic [7:0]    in_data;
    logic [N-1:0]  cfg_sel;
    logic          ctrl_we, wt_we, init_mode_acc, neuron_mode, run_start, err;
    logic [2:0]    decay_mode, init_mode_adder;
    logic [1:0]    adder_model;
    logic [AW-1:0] wt_addr;
    logic [VW-1:0] wt_value;

    neuron_cfg_ctrl #(.N_NEURONS(N), .ADDR_W(AW), .VALUE_W(VW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_sel(cfg_sel), .ctrl_we(ctrl_we), .decay_mode(decay_mode),
        .init_mode_adder(init_mode_adder), .adder_model(adder_model),
        .init_mode_acc(init_mode_acc), .wt_we(wt_we), .wt_addr(wt_addr), .wt_value(wt_value),
        .neuron_mode(neuron_mode), .run_start(run_start), .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [2:0]    m_decay, m_imadd;
    logic [1:0]    m_am;
    logic          m_acc, m_mode;
    logic [AW-1:0] m_addr;
    logic [VW-1:0] m_value;
    logic [EW-1:0] exp_q[$];
    logic [7:0]    pkt[$];
    int            first_acc;

    function automatic logic [EW-1:0] make_ev(input logic [3:0] kind, input logic [N-1:0] sel);
        return {kind, sel, m_decay, m_imadd, m_am, m_acc, m_addr, m_value, m_mode};
    endfunction

    task automatic model_reset();
        m_decay = 0; m_imadd = 0; m_am = 0; m_acc = 0;
        m_addr = 0; m_value = 0; m_mode = 1;
        exp_q.delete();
    endtask

    // Packet-level model: one expected strobe/err/run event per packet.
    task automatic model_pkt();
        logic [7:0]  op, id, x, c0, c1;
        logic [15:0] a16;
        logic        ok;
        logic [N-1:0] sel;
        int n;
        n  = pkt.size();
        op = pkt[0];
        if (op == 8'hFF) begin
            m_mode = 0;
            exp_q.push_back(make_ev(4'b0001, '0));
        end else if (op >= 8'h01 && op <= 8'h03) begin
            m_mode = 1;
            id = pkt[1];
            ok = (id == 8'hFF) || (id < N);
`ifdef NEURON_CFG_CHECKSUM_EN
            x = 0;
            for (int i = 0; i < n - 1; i++) x = x ^ pkt[i];
            if (pkt[n-1] !== x) ok = 0;
`else
            x = 0;
`endif
            if (!ok) begin
                exp_q.push_back(make_ev(4'b0010, '0));
            end else begin
                sel = (id == 8'hFF) ? '1 : N'(1 << id);
                if (op == 8'h01) begin
                    c0 = pkt[2]; c1 = pkt[3];
                    m_decay = c0[2:0]; m_imadd = c0[5:3]; m_am = c0[7:6]; m_acc = c1[0];
                    exp_q.push_back(make_ev(4'b1000, sel));
                end else if (op == 8'h02) begin
                    a16 = {pkt[3], pkt[2]};
                    m_addr  = a16[AW-1:0];
                    m_value = {pkt[7], pkt[6], pkt[5], pkt[4]};
                    exp_q.push_back(make_ev(4'b0100, sel));
                end else begin
                    m_addr  = m_addr + 1;
                    m_value = {pkt[5], pkt[4], pkt[3], pkt[2]};
                    exp_q.push_back(make_ev(4'b0100, sel));
                end
            end
        end else begin
            exp_q.push_back(make_ev(4'b0010, '0));
        end
    endtask

    // scoreboard monitor: every strobe cycle must match the head of exp_q
    always @(negedge clk) begin
        logic [EW-1:0] obs, e;
        if (!rst) begin
            obs = {ctrl_we, wt_we, err, run_start, cfg_sel, decay_mode, init_mode_adder,
                   adder_model, init_mode_acc, wt_addr, wt_value, neuron_mode};
            total++;
            if (ctrl_we || wt_we || err || run_start) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL event_unexpected: got %h, none expected (t=%0t)", obs, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL event: got %h expected %h (t=%0t)", obs, e, $time);
                    end
                end
            end else if (cfg_sel !== '0) begin
                bad++;
                $display("FAIL sel_idle: cfg_sel=%b expected 0 (t=%0t)", cfg_sel, $time);
            end
        end
    end

    // driver tasks (always entered and left on a negedge)
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: in_ready=%b expected 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic add_chk(input logic corrupt);
`ifdef NEURON_CFG_CHECKSUM_EN
        logic [7:0] x;
        x = 0;
        foreach (pkt[i]) x = x ^ pkt[i];
        pkt.push_back(x ^ {7'd0, corrupt});
`else
        if (corrupt) pkt.push_back(8'h00);
        if (corrupt) void'(pkt.pop_back());
`endif
    endtask

    task automatic send_pkt(input int gap_max);
        int t;
        model_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0, t);
            if (i == 0) first_acc = t;
        end
        pkt.delete();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // scenario tasks
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        total++;
        if (neuron_mode !== 1'b1) begin bad++; $display("FAIL reset_mode: got %b expected 1", neuron_mode); end
        total++;
        if ({ctrl_we, wt_we, err, run_start} !== 4'b0) begin
            bad++; $display("FAIL reset_strobes: got %b expected 0000", {ctrl_we, wt_we, err, run_start});
        end
        total++;
        if (cfg_sel !== '0) begin bad++; $display("FAIL reset_sel: got %b expected 0", cfg_sel); end
        total++;
        if ({decay_mode, init_mode_adder, adder_model, init_mode_acc, wt_addr, wt_value} !== '0) begin
            bad++; $display("FAIL reset_fields: addr=%h value=%h decay=%0d expected all 0",
                            wt_addr, wt_value, decay_mode);
        end
    endtask

    task automatic test_set_ctrl();
        pkt = '{8'h01, 8'h02, 8'hAB, 8'h01}; add_chk(0); send_pkt(1);
        settle();
        total++;
        if ({decay_mode, init_mode_adder, adder_model, init_mode_acc} !== {3'd3, 3'd5, 2'd2, 1'b1}) begin
            bad++; $display("FAIL set_ctrl_fields: decay=%0d adder=%0d model=%0d acc=%0d expected 3 5 2 1",
                            decay_mode, init_mode_adder, adder_model, init_mode_acc);
        end
    endtask

    task automatic test_weights();
        pkt = '{8'h02, 8'h00, 8'h05, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; add_chk(0); send_pkt(1);
        settle();
        total++;
        if (wt_addr !== 10'h105 || wt_value !== 32'hDEADBEEF) begin
            bad++; $display("FAIL addr_set: addr=%h value=%h expected 105 deadbeef", wt_addr, wt_value);
        end
        pkt = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}; add_chk(0); send_pkt(0);
        settle();
        total++;
        if (wt_addr !== 10'h106 || wt_value !== 32'h44332211) begin
            bad++; $display("FAIL weight_set: addr=%h value=%h expected 106 44332211", wt_addr, wt_value);
        end
    endtask

    task automatic test_wrap();
        pkt = '{8'h02, 8'h01, 8'hFF, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04}; add_chk(0); send_pkt(0);
        pkt = '{8'h03, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}; add_chk(0); send_pkt(0);
        settle();
        total++;
        if (wt_addr !== 10'h000) begin bad++; $display("FAIL addr_wrap: addr=%h expected 000", wt_addr); end
    endtask

    task automatic test_broadcast_bad_id();
        pkt = '{8'h01, 8'hFF, 8'h00, 8'h00}; add_chk(0); send_pkt(1);
        pkt = '{8'h01, 8'h09, 8'h3F, 8'h01}; add_chk(0); send_pkt(1);
        settle();
        total++;
        if (decay_mode !== 3'd0 || init_mode_acc !== 1'b0) begin
            bad++; $display("FAIL bad_id_fields: decay=%0d acc=%0d expected 0 0", decay_mode, init_mode_acc);
        end
    endtask

    task automatic test_end_unknown();
        pkt = '{8'hFF}; send_pkt(0);
        settle();
        total++;
        if (neuron_mode !== 1'b0) begin bad++; $display("FAIL end_mode: got %b expected 0", neuron_mode); end
        pkt = '{8'h07}; send_pkt(0);
        settle();
        total++;
        if (neuron_mode !== 1'b0) begin bad++; $display("FAIL unknown_mode: got %b expected 0", neuron_mode); end
    endtask

    task automatic test_reset_mid_packet();
        int t;
        send_byte(8'h02, 0, t);
        send_byte(8'h00, 0, t);
        send_byte(8'h05, 0, t);
        test_reset();
        pkt = '{8'h01, 8'h00, 8'h00, 8'h00}; add_chk(0); send_pkt(0);
        settle();
    endtask

    task automatic test_back_to_back();
        int t0, len;
        pkt = '{8'h01, 8'h01, 8'h12, 8'h00}; add_chk(0);
        len = pkt.size();
        send_pkt(0); t0 = first_acc;
        pkt = '{8'h01, 8'h03, 8'h34, 8'h01}; add_chk(0); send_pkt(0);
        total++;
        if (first_acc - t0 !== len + 1) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", first_acc - t0, len + 1);
        end
        pkt = '{8'h07}; send_pkt(0); t0 = first_acc;
        pkt = '{8'hFF}; send_pkt(0);
        total++;
        if (first_acc - t0 !== 1) begin
            bad++; $display("FAIL b2b_single: got %0d cycles expected 1", first_acc - t0);
        end
        settle();
    endtask

    task automatic test_checksum();
`ifdef NEURON_CFG_CHECKSUM_EN
        pkt = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h06}; send_pkt(0);
        pkt = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h05}; send_pkt(0);
        settle();
        total++;
        if (decay_mode !== 3'd7) begin bad++; $display("FAIL chk_fields: decay=%0d expected 7", decay_mode); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] id;
        int kind, r;
        for (int p = 0; p < 80; p++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      id = 8'(r);
            else if (r < 6) id = 8'hFF;
            else            id = 8'($urandom_range(4, 254));
            kind = $urandom_range(0, 4);
            pkt.delete();
            case (kind)
                0: begin
                    pkt.push_back(8'h01); pkt.push_back(id);
                    repeat (2) pkt.push_back(8'($urandom));
                end
                1: begin
                    pkt.push_back(8'h02); pkt.push_back(id);
                    repeat (6) pkt.push_back(8'($urandom));
                end
                2: begin
                    pkt.push_back(8'h03); pkt.push_back(id);
                    repeat (4) pkt.push_back(8'($urandom));
                end
                3: pkt.push_back(8'hFF);
                default: pkt.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 254)));
            endcase
            if (kind <= 2) add_chk($urandom_range(0, 7) == 0);
            send_pkt(2);
        end
        settle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        model_reset();
        test_reset();
        test_set_ctrl();
        test_weights();
        test_wrap();
        test_broadcast_bad_id();
        test_end_unknown();
        test_reset_mid_packet();
        test_back_to_back();
        test_checksum();
        test_random();
        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL events_missing: %0d expected events never seen", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
